note_recorder: RTL and testbench



---
 rtl/note_recorder_pkg.sv | 21 ++
 rtl/note_buffer.sv | 32 +++
 rtl/note_recorder.sv | 207 ++++++++++++++++++++
 tb/tb_note_recorder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/note_recorder_pkg.sv
// Shared constants for the note recorder: event field widths and state encoding.
package note_recorder_pkg;

    localparam int unsigned OCTAVE_BITS = 2;
    localparam int unsigned NOTE_BITS   = 3;
    localparam int unsigned LENGTH_BITS = 3;

    localparam logic [2:0] RECORDER_IDLE       = 3'd0;
    localparam logic [2:0] RECORDER_RECORD     = 3'd1;
    localparam logic [2:0] RECORDER_PLAY_FETCH = 3'd2;
    localparam logic [2:0] RECORDER_PLAY_GAP   = 3'd3;
    localparam logic [2:0] RECORDER_PLAY_ISSUE = 3'd4;
    localparam logic [2:0] RECORDER_PLAY_WAIT  = 3'd5;

    // True for every replay state.
    function automatic logic is_play(input logic [2:0] st);
        return (st == RECORDER_PLAY_FETCH) || (st == RECORDER_PLAY_GAP) ||
               (st == RECORDER_PLAY_ISSUE) || (st == RECORDER_PLAY_WAIT);
    endfunction

endpackage

// File: rtl/note_buffer.sv
// Event store: DEPTH-entry simple dual-port RAM, one write port, registered read.
module note_buffer #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; output holds until the next read enable.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Record-and-replay of free-play note events.
// Optional feature macro NOTE_RECORDER_GAP_EN: stores tick gaps between hits and
// reproduces them on replay (adds the PLAY_GAP state and a gap counter).
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned OCTAVE_W = OCTAVE_BITS,
    parameter int unsigned NOTE_W   = NOTE_BITS,
    parameter int unsigned LENGTH_W = LENGTH_BITS,
    parameter int unsigned GAP_W    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rec_en,
    input  logic                       play_start,
    input  logic                       play_stop,
    input  logic                       tick,
    input  logic                       hit_valid,
    input  logic [OCTAVE_W-1:0]        hit_octave,
    input  logic [NOTE_W-1:0]          hit_note,
    input  logic [LENGTH_W-1:0]        hit_length,
    output logic                       snd_start,
    output logic [OCTAVE_W-1:0]        snd_octave,
    output logic [NOTE_W-1:0]          snd_note,
    output logic [LENGTH_W-1:0]        snd_length,
    input  logic                       snd_over,
    output logic                       playing,
    output logic                       recording,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned FIELD_W = OCTAVE_W + NOTE_W + LENGTH_W;
`ifdef NOTE_RECORDER_GAP_EN
    localparam int unsigned WORD_W  = FIELD_W + GAP_W;
`else
    localparam int unsigned WORD_W  = FIELD_W;
    localparam int unsigned unused_gap_w = GAP_W;
    logic unused_tick;
    assign unused_tick = tick;
`endif

    logic [2:0]          state, state_next;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                wait_first;
    logic [OCTAVE_W-1:0] oct_hold;
    logic [NOTE_W-1:0]   note_hold;
    logic [LENGTH_W-1:0] len_hold;

    logic                we, re, last;
    logic [WORD_W-1:0]   wdata, rdata;
    logic [FIELD_W-1:0]  rd_fields;
    logic [OCTAVE_W-1:0] rd_oct;
    logic [NOTE_W-1:0]   rd_note;
    logic [LENGTH_W-1:0] rd_len;

`ifdef NOTE_RECORDER_GAP_EN
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    rd_gap;
    assign rd_gap = rdata[GAP_W-1:0];
    // The first entry of a take has no predecessor, so its gap is zero.
    assign wdata  = {hit_octave, hit_note, hit_length,
                     (wr_ptr == '0) ? {GAP_W{1'b0}} : gap_cnt};
`else
    assign wdata  = {hit_octave, hit_note, hit_length};
`endif

    assign full      = (count == CW'(DEPTH));
    assign we        = (state == RECORDER_RECORD) && hit_valid && !full;
    assign re        = (state == RECORDER_PLAY_FETCH);
    assign last      = ({1'b0, rd_ptr} == (count - CW'(1)));
    assign rd_fields = rdata[WORD_W-1 -: FIELD_W];
    assign rd_oct    = rd_fields[FIELD_W-1 -: OCTAVE_W];
    assign rd_note   = rd_fields[LENGTH_W +: NOTE_W];
    assign rd_len    = rd_fields[LENGTH_W-1:0];

    note_buffer #(
        .DEPTH  (DEPTH),
        .WIDTH  (WORD_W),
        .ADDR_W (AW)
    ) u_buffer (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Next-state decode; play_stop overrides everything while replaying.
    always_comb begin
        state_next = state;
        case (state)
            RECORDER_IDLE: begin
                if (rec_en) begin
                    state_next = RECORDER_RECORD;
                end else if (play_start && (count != '0)) begin
                    state_next = RECORDER_PLAY_FETCH;
                end
            end
            RECORDER_RECORD: begin
                if (!rec_en) begin
                    state_next = RECORDER_IDLE;
                end
            end
            RECORDER_PLAY_FETCH: begin
`ifdef NOTE_RECORDER_GAP_EN
                state_next = RECORDER_PLAY_GAP;
`else
                state_next = RECORDER_PLAY_ISSUE;
`endif
            end
`ifdef NOTE_RECORDER_GAP_EN
            RECORDER_PLAY_GAP: begin
                if (gap_cnt >= rd_gap) begin
                    state_next = RECORDER_PLAY_ISSUE;
                end
            end
`endif
            RECORDER_PLAY_ISSUE: state_next = RECORDER_PLAY_WAIT;
            RECORDER_PLAY_WAIT: begin
                // snd_over may still be high from the previous note in the first cycle.
                if (snd_over && !wait_first) begin
                    state_next = last ? RECORDER_IDLE : RECORDER_PLAY_FETCH;
                end
            end
            default: state_next = RECORDER_IDLE;
        endcase
        if (is_play(state) && play_stop) begin
            state_next = RECORDER_IDLE;
        end
    end

    // State, pointers, counters and held note fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RECORDER_IDLE;
            playing    <= 1'b0;
            recording  <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wait_first <= 1'b0;
            oct_hold   <= '0;
            note_hold  <= '0;
            len_hold   <= '0;
        end else begin
            state      <= state_next;
            playing    <= is_play(state_next);
            recording  <= (state_next == RECORDER_RECORD);
            wait_first <= (state == RECORDER_PLAY_ISSUE);
            if ((state == RECORDER_IDLE) && rec_en) begin
                count  <= '0;
                wr_ptr <= '0;
            end else if (we) begin
                count  <= count + CW'(1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if ((state == RECORDER_IDLE) && (state_next == RECORDER_PLAY_FETCH)) begin
                rd_ptr <= '0;
            end else if ((state == RECORDER_PLAY_WAIT) &&
                         (state_next == RECORDER_PLAY_FETCH)) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (state == RECORDER_PLAY_ISSUE) begin
                oct_hold  <= rd_oct;
                note_hold <= rd_note;
                len_hold  <= rd_len;
            end
        end
    end

`ifdef NOTE_RECORDER_GAP_EN
    // One counter serves both roles: ticks since last hit while recording,
    // ticks waited so far while in PLAY_GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if ((state == RECORDER_IDLE) && rec_en) begin
            gap_cnt <= '0;
        end else if (state == RECORDER_RECORD) begin
            if (hit_valid) begin
                gap_cnt <= '0;
            end else if (tick && (gap_cnt != '1)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end else if (state == RECORDER_PLAY_FETCH) begin
            gap_cnt <= '0;
        end else if ((state == RECORDER_PLAY_GAP) && tick && (gap_cnt != '1)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`endif

    // Fields come straight from the RAM in the issue cycle, then from the hold registers.
    always_comb begin
        snd_start  = (state == RECORDER_PLAY_ISSUE);
        snd_octave = snd_start ? rd_oct  : oct_hold;
        snd_note   = snd_start ? rd_note : note_hold;
        snd_length = snd_start ? rd_len  : len_hold;
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed self-checking bench for note_recorder (default build, DEPTH=32).
module tb_note_recorder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rec_en = 1'b0, play_start = 1'b0, play_stop = 1'b0, tick = 1'b0;
    logic       hit_valid = 1'b0;
    logic [1:0] hit_octave = '0;
    logic [2:0] hit_note = '0, hit_length = '0;
    logic       snd_start, snd_over = 1'b0, playing, recording, full;
    logic [1:0] snd_octave;
    logic [2:0] snd_note, snd_length;
    logic [5:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_oct [64];
    int exp_note[64];
    int exp_len [64];
    int starts;

    note_recorder dut (
        .clk        (clk),
        .rst        (rst),
        .rec_en     (rec_en),
        .play_start (play_start),
        .play_stop  (play_stop),
        .tick       (tick),
        .hit_valid  (hit_valid),
        .hit_octave (hit_octave),
        .hit_note   (hit_note),
        .hit_length (hit_length),
        .snd_start  (snd_start),
        .snd_octave (snd_octave),
        .snd_note   (snd_note),
        .snd_length (snd_length),
        .snd_over   (snd_over),
        .playing    (playing),
        .recording  (recording),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; all driving and sampling happens 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_hit(input int idx, input int o, input int n, input int l);
        hit_valid  = 1'b1;
        hit_octave = 2'(o);
        hit_note   = 3'(n);
        hit_length = 3'(l);
        exp_oct[idx]  = o;
        exp_note[idx] = n;
        exp_len[idx]  = l;
        step();
        hit_valid = 1'b0;
    endtask

    // Replays the buffer; snd_over pulses 5 cycles after each snd_start, or play_stop
    // is asserted there instead once stop_at notes have started.
    task automatic play_run(input int stop_at, output int n_starts);
        int since;
        int over_cyc;
        since    = -1;
        over_cyc = -1;
        n_starts = 0;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        check("fetch_playing", playing, 1);
        for (int cyc = 0; cyc < 600 && playing; cyc++) begin
            snd_over = 1'b0;
            if (snd_start) begin
                if (n_starts < 64) begin
                    check("snd_octave", snd_octave, exp_oct[n_starts]);
                    check("snd_note", snd_note, exp_note[n_starts]);
                    check("snd_length", snd_length, exp_len[n_starts]);
                end
                if (over_cyc >= 0) check("over_to_start", cyc - over_cyc, 2);
                else               check("first_latency", cyc, 1);
                n_starts++;
                since = 0;
            end
            if (since == 5) begin
                if (n_starts == stop_at) play_stop = 1'b1;
                else begin
                    snd_over = 1'b1;
                    over_cyc = cyc;
                end
            end
            if (since >= 0) since++;
            step();
            play_stop = 1'b0;
        end
        snd_over = 1'b0;
        check("play_done", playing, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (snd_start) seen++;
            step();
        end
        check(tag, seen, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_playing", playing, 0);
        check("rst_recording", recording, 0);
        check("rst_snd_start", snd_start, 0);
        check("rst_snd_fields", {snd_octave, snd_note, snd_length}, 0);

        // play_start with an empty buffer is ignored
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        check("empty_play_playing", playing, 0);
        expect_quiet("empty_play_start", 8);

        // three-note take
        rec_en = 1'b1;
        step();
        check("rec_recording", recording, 1);
        rec_hit(0, 1, 3, 2);
        check("count_1", count, 1);
        rec_hit(1, 2, 5, 1);
        check("count_2", count, 2);
        rec_hit(2, 0, 0, 4);
        check("count_3", count, 3);
        check("rec_recording_3", recording, 1);
        rec_en = 1'b0;
        step();
        check("idle_recording", recording, 0);
        check("idle_count", count, 3);

        play_run(-1, starts);
        check("three_starts", starts, 3);
        expect_quiet("after_three", 6);

        // 40 hits into a 32-entry buffer
        rec_en = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            rec_hit(i, i % 4, (i / 4) % 8, (i * 3) % 8);
        end
        check("full_flag", full, 1);
        check("full_count", count, 32);
        rec_en = 1'b0;
        step();
        play_run(-1, starts);
        check("full_starts", starts, 32);

        // abort during the second note's wait, then restart from entry 0
        play_run(2, starts);
        check("stop_starts", starts, 2);
        expect_quiet("stop_no_third", 10);
        play_run(3, starts);
        check("restart_starts", starts, 3);

        // reset in the middle of a note
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        step();
        check("mid_issue", snd_start, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_snd_start", snd_start, 0);
        check("mid_rst_playing", playing, 0);
        check("mid_rst_count", count, 0);
        expect_quiet("mid_rst_quiet", 6);

        // refill, then rec_en and play_start together: record wins and clears the take
        rec_en = 1'b1;
        step();
        rec_hit(0, 3, 7, 5);
        rec_en = 1'b0;
        step();
        check("refill_count", count, 1);
        rec_en = 1'b1;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        check("both_recording", recording, 1);
        check("both_playing", playing, 0);
        check("both_count", count, 0);
        rec_en = 1'b0;
        step();
        expect_quiet("both_no_start", 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
